// File: rtl/uc_multiciclo_pkg.sv
// Shared constants for the multicycle RV32I control unit: FSM state codes,
// opcodes, ALU operation classes and ALU control encodings.
package uc_multiciclo_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0,
                         S_DECODE   = 4'd1,
                         S_MEMADR   = 4'd2,
                         S_MEMREAD  = 4'd3,
                         S_MEMWB    = 4'd4,
                         S_MEMWRITE = 4'd5,
                         S_EXECR    = 4'd6,
                         S_EXECI    = 4'd7,
                         S_ALUWB    = 4'd8,
                         S_BRANCH   = 4'd9,
                         S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011,
                         OP_SW  = 7'b0100011,
                         OP_R   = 7'b0110011,
                         OP_I   = 7'b0010011,
                         OP_JAL = 7'b1101111,
                         OP_BR  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00,
                         ALUOP_SUB   = 2'b01,
                         ALUOP_FUNCT = 2'b10;

  // 4-bit codes; a 3-bit ALU uses the low bits of the base operations only
  localparam logic [3:0] ALU_ADD = 4'b0000,
                         ALU_SUB = 4'b0001,
                         ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011,
                         ALU_XOR = 4'b0100,
                         ALU_SLT = 4'b0101,
                         ALU_SLL = 4'b0110,
                         ALU_SRL = 4'b0111,
                         ALU_SRA = 4'b1000;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 3'b001;
      OP_BR:   return 3'b010;
      OP_JAL:  return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, mux selects and enables out.
interface uc_multiciclo_if #(parameter int ALU_CTRL_W = 3);
  logic [6:0]            op;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic                  zero;
  logic                  memReady;
  logic                  pcWrite;
  logic                  adrSrc;
  logic                  memWrite;
  logic                  irWrite;
  logic [1:0]            resultSrc;
  logic [1:0]            aluSrcA;
  logic [1:0]            aluSrcB;
  logic [2:0]            immSrc;
  logic                  regWrite;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic                  illegalOp;
  logic [3:0]            state;

  modport master (
    input  op, f3, f7, zero, memReady,
    output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
           immSrc, regWrite, aluControl, illegalOp, state
  );

  modport slave (
    output op, f3, f7, zero, memReady,
    input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
           immSrc, regWrite, aluControl, illegalOp, state
  );
endinterface

// File: rtl/uc_multiciclo_alu_deco_ext.sv
// Combinational ALU decoder: aluOp/f3/f7[5]/op[5] -> aluControl, plus a flag saying
// whether f3 names an operation this ALU width can perform.
module alu_deco_ext
  import uc_multiciclo_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            f3,
  input  logic                  f7_5,
  input  logic                  op_5,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  f3_ok
);

  localparam bit EXT_ALU = (ALU_CTRL_W >= 4);

  logic [3:0] f3_code;
  logic [3:0] code;

  // f3_ok is independent of alu_op so DECODE can flag illegal R/I forms early
  always_comb begin
    f3_ok   = 1'b1;
    f3_code = ALU_ADD;
    case (f3)
      3'b000: f3_code = (op_5 && f7_5) ? ALU_SUB : ALU_ADD;
      3'b010: f3_code = ALU_SLT;
      3'b110: f3_code = ALU_OR;
      3'b111: f3_code = ALU_AND;
      3'b100: begin
        f3_code = EXT_ALU ? ALU_XOR : ALU_ADD;
        f3_ok   = EXT_ALU;
      end
      3'b001: begin
        f3_code = EXT_ALU ? ALU_SLL : ALU_ADD;
        f3_ok   = EXT_ALU;
      end
      3'b101: begin
        f3_code = !EXT_ALU ? ALU_ADD : (f7_5 ? ALU_SRA : ALU_SRL);
        f3_ok   = EXT_ALU;
      end
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      default:   code = f3_code;
    endcase
  end

  assign alu_control = code[ALU_CTRL_W-1:0];

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM over fetch/decode/execute/memory/writeback,
// stalling on memReady in FETCH, MEMREAD and MEMWRITE.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  uc_multiciclo_if.master bus
);

  logic [3:0]            state_q;
  logic [3:0]            next_state;
  logic [3:0]            decode_next;
  logic [1:0]            alu_op;
  logic [1:0]            result_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic                  pc_update;
  logic                  illegal;
  logic                  f3_ok;
  logic                  br_ok;
  logic                  taken;
  logic [ALU_CTRL_W-1:0] alu_ctl;
  logic                  unused_f7;

  assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

  alu_deco_ext #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_deco (
    .alu_op      (alu_op),
    .f3          (bus.f3),
    .f7_5        (bus.f7[5]),
    .op_5        (bus.op[5]),
    .alu_control (alu_ctl),
    .f3_ok       (f3_ok)
  );

  assign br_ok = (bus.f3 == 3'b000) || (EXT_BRANCH && (bus.f3 == 3'b001));
  assign taken = ((bus.f3 == 3'b000) && bus.zero) ||
                 (EXT_BRANCH && (bus.f3 == 3'b001) && !bus.zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  always_comb begin
    illegal     = 1'b0;
    decode_next = S_FETCH;
    case (bus.op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_R:   if (f3_ok) decode_next = S_EXECR;  else illegal = 1'b1;
      OP_I:   if (f3_ok) decode_next = S_EXECI;  else illegal = 1'b1;
      OP_JAL: decode_next = S_JAL;
      OP_BR:  if (br_ok) decode_next = S_BRANCH; else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:    next_state = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE:   next_state = decode_next;
      S_MEMADR:   next_state = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = bus.memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = bus.memReady ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore output table; only FETCH looks at memReady
  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.memReady;
        pc_update  = bus.memReady;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcWrite    = pc_update || ((state_q == S_BRANCH) && taken);
  assign bus.adrSrc     = adr_src;
  assign bus.memWrite   = mem_write;
  assign bus.irWrite    = ir_write;
  assign bus.resultSrc  = result_src;
  assign bus.aluSrcA    = alu_src_a;
  assign bus.aluSrcB    = alu_src_b;
  assign bus.immSrc     = imm_src_of(bus.op);
  assign bus.regWrite   = reg_write;
  assign bus.aluControl = alu_ctl;
  assign bus.illegalOp  = (state_q == S_DECODE) && illegal;
  assign bus.state      = state_q;

endmodule
